// File: rtl/regfile_wport_arb.sv
// Register-file write-port arbiter.
//
// Two requesters (r0 = ALU, r1 = load unit) compete for a single register-file
// write port. After reset, or on a scrub pulse, the block runs a zero-fill
// sweep over every register. Only after the sweep does it arbitrate between
// the requesters.
//
// Arbitration:
//   - Only one requester valid: that requester wins.
//   - Both requesters valid: a 1-bit round-robin pointer picks the winner.
//
// All write-port outputs are registered. Each accepted request appears on the
// write port one cycle after it is accepted.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   scrub               one-cycle pulse requesting a zero-fill sweep
//   rN_valid/addr/data  requester N write request
//   rN_ready            requester N accepted this cycle (when rN_valid is high)
//   Wen, Wd, Wdat       register-file write enable / address / data
//   busy                high while the zero-fill sweep is in progress

module regfile_wport_arb #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scrub,
  input  logic          r0_valid,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_data,
  output logic          r0_ready,
  input  logic          r1_valid,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_data,
  output logic          r1_ready,
  output logic          Wen,
  output logic [AW-1:0] Wd,
  output logic [DW-1:0] Wdat,
  output logic          busy
);

  typedef enum logic {StInit, StRun} state_e;

  localparam logic [AW-1:0] CntLast = {AW{1'b1}};

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          prio_q, prio_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] wd_q, wd_d;
  logic [DW-1:0] wdat_q, wdat_d;
  // Marks that the write now on the port came from the sweep, so busy stays
  // high through the final sweep write.
  logic          sweep_q, sweep_d;

  logic          gnt0, gnt1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      wen_q   <= 1'b0;
      wd_q    <= '0;
      wdat_q  <= '0;
      sweep_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      wen_q   <= wen_d;
      wd_q    <= wd_d;
      wdat_q  <= wdat_d;
      sweep_q <= sweep_d;
    end
  end

  // Grant decode
  // prio_q == 0 favours r0 when both requesters are valid.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StRun) begin
      gnt0 = r0_valid & (~r1_valid | ~prio_q);
      gnt1 = r1_valid & ~gnt0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    wen_d   = 1'b0;
    wd_d    = wd_q;
    wdat_d  = wdat_q;
    sweep_d = 1'b0;
    unique case (state_q)
      StInit: begin
        // Requester inputs and scrub are ignored during the sweep.
        wen_d   = 1'b1;
        wd_d    = cnt_q;
        wdat_d  = '0;
        sweep_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (gnt0) begin
          wen_d  = 1'b1;
          wd_d   = r0_addr;
          wdat_d = r0_data;
        end else if (gnt1) begin
          wen_d  = 1'b1;
          wd_d   = r1_addr;
          wdat_d = r1_data;
        end
        // The pointer moves only on contention; it then points at the loser.
        if (r0_valid && r1_valid) begin
          prio_d = gnt0;
        end
        // The write accepted this cycle is still issued; the sweep starts after it.
        if (scrub) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Outputs
  always_comb begin
    r0_ready = gnt0;
    r1_ready = gnt1;
    Wen      = wen_q;
    Wd       = wd_q;
    Wdat     = wdat_q;
    busy     = (state_q == StInit) | sweep_q;
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
module tb_regfile_wport_arb;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          scrub;
  logic          r0_valid, r1_valid;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_data, r1_data;
  logic          r0_ready, r1_ready;
  logic          Wen;
  logic [AW-1:0] Wd;
  logic [DW-1:0] Wdat;
  logic          busy;

  always #5 clk = ~clk;

  regfile_wport_arb #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scrub    (scrub),
    .r0_valid (r0_valid),
    .r0_addr  (r0_addr),
    .r0_data  (r0_data),
    .r0_ready (r0_ready),
    .r1_valid (r1_valid),
    .r1_addr  (r1_addr),
    .r1_data  (r1_data),
    .r1_ready (r1_ready),
    .Wen      (Wen),
    .Wd       (Wd),
    .Wdat     (Wdat),
    .busy     (busy)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          sw;
  } wr_t;

  wr_t           exp_q[$];
  int            checks = 0;
  int            errors = 0;

  // Reference model state
  logic          m_run;
  logic [AW-1:0] m_cnt;
  logic          m_prio;
  logic [AW-1:0] last_wd;
  logic [DW-1:0] last_wdat;
  logic [DW-1:0] rf_shadow [2**AW];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run     = 1'b0;
    m_cnt     = '0;
    m_prio    = 1'b0;
    last_wd   = '0;
    last_wdat = '0;
    exp_q.delete();
  endtask

  // One clock of stimulus: drive inputs, check readies, predict, clock, check port.
  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic sc);
    logic g0, g1;
    wr_t  e;
    r0_valid = v0; r0_addr = a0; r0_data = d0;
    r1_valid = v1; r1_addr = a1; r1_data = d1;
    scrub    = sc;
    #1;
    g0 = m_run & v0 & (~v1 | ~m_prio);
    g1 = m_run & v1 & ~g0;
    chk("r0_ready", {31'd0, r0_ready}, {31'd0, g0});
    chk("r1_ready", {31'd0, r1_ready}, {31'd0, g1});
    if (!m_run) begin
      exp_q.push_back('{a: m_cnt, d: '0, sw: 1'b1});
      if (m_cnt == {AW{1'b1}}) m_run = 1'b1;
      m_cnt = m_cnt + 1'b1;
    end else begin
      if (g0) exp_q.push_back('{a: a0, d: d0, sw: 1'b0});
      if (g1) exp_q.push_back('{a: a1, d: d1, sw: 1'b0});
      if (v0 && v1) m_prio = g0;
      if (sc) begin
        m_run = 1'b0;
        m_cnt = '0;
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("Wen", {31'd0, Wen}, 32'd1);
      chk("Wd", {29'd0, Wd}, {29'd0, e.a});
      chk("Wdat", {24'd0, Wdat}, {24'd0, e.d});
      chk("busy", {31'd0, busy}, {31'd0, ~m_run | e.sw});
      last_wd   = e.a;
      last_wdat = e.d;
    end else begin
      chk("Wen_idle", {31'd0, Wen}, 32'd0);
      chk("Wd_hold", {29'd0, Wd}, {29'd0, last_wd});
      chk("Wdat_hold", {24'd0, Wdat}, {24'd0, last_wdat});
      chk("busy_idle", {31'd0, busy}, {31'd0, ~m_run});
    end
    if (Wen === 1'b1) rf_shadow[Wd] = Wdat;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_Wen"}, {31'd0, Wen}, 32'd0);
    chk({tag, "_Wd"}, {29'd0, Wd}, 32'd0);
    chk({tag, "_Wdat"}, {24'd0, Wdat}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_r0_ready"}, {31'd0, r0_ready}, 32'd0);
    chk({tag, "_r1_ready"}, {31'd0, r1_ready}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) rf_shadow[i] = 8'hFF;
    model_reset();
    rst_n    = 1'b0;
    scrub    = 1'b0;
    r0_valid = 1'b1; r0_addr = 3'd1; r0_data = 8'h12;
    r1_valid = 1'b1; r1_addr = 3'd2; r1_data = 8'h34;
    #2;
    chk_reset_outputs("reset");
    #1;
    rst_n = 1'b1;

    // First part of the sweep, with an ignored scrub, then reset at sweep cycle 4.
    idle(2);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    idle(1);
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    #1;
    rst_n = 1'b1;
    model_reset();

    // Full sweep after release, then first idle RUN cycle.
    idle(8);
    idle(1);

    // Single requester r0.
    step(1'b1, 3'd3, 8'h5A, 1'b0, '0, '0, 1'b0);

    // Continuous contention, alternating grants.
    for (int i = 0; i < 4; i++) step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0);

    // Same address from both requesters.
    step(1'b1, 3'd4, 8'hAA, 1'b1, 3'd4, 8'hBB, 1'b0);
    step(1'b1, 3'd4, 8'hAA, 1'b1, 3'd4, 8'hBB, 1'b0);
    step(1'b0, '0, '0, 1'b1, 3'd4, 8'hBB, 1'b0);
    idle(1);
    chk("reg4_final", {24'd0, rf_shadow[4]}, 32'hBB);

    // r1 alone, independent of the pointer.
    step(1'b0, '0, '0, 1'b1, 3'd6, 8'h3C, 1'b0);

    // Scrub while r1 is granted, then r1 waits through the sweep.
    step(1'b0, '0, '0, 1'b1, 3'd5, 8'h77, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, '0, '0, 1'b1, 3'd6, 8'h66, 1'b0);
    idle(2);
    chk("reg5_scrubbed", {24'd0, rf_shadow[5]}, 32'h00);
    chk("reg6_final", {24'd0, rf_shadow[6]}, 32'h66);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
